// File: rtl/divisibility_scheduler.sv
// Round-robin shared serial mod-7 engine.
// Clock/Reset; Req_valid/Req_data/Req_ready in; Res_* out; Busy.
module divisibility_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req_valid,
  input  logic [NREQ*WIDTH-1:0] Req_data,
  output logic [NREQ-1:0]       Req_ready,
  output logic                  Res_valid,
  input  logic                  Res_ready,
  output logic [IDW-1:0]        Res_id,
  output logic [2:0]            Res_remainder,
  output logic                  Res_divisible,
  output logic                  Busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       rem;
  logic [2:0]       rem_nx;
  logic [3:0]       rem2;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   res_id;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   ix;
  logic             gnt_found;
  logic [WIDTH-1:0] gnt_data;
  logic             take;

  // Search starts just after the last winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    ix        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      ix = IDW'((int'(last) + k) % NREQ);
      if (!gnt_found && Req_valid[ix]) begin
        gnt_found = 1'b1;
        gnt_idx   = ix;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i))
        gnt_data = Req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    Req_ready = '0;
    if (state == IDLE && gnt_found)
      Req_ready[gnt_idx] = 1'b1;
  end

  assign take = (state == IDLE) && gnt_found;

  // 2*rem+bit is at most 13, so one subtract keeps it in 0..6.
  assign rem2   = {rem, sreg[WIDTH-1]};
  assign rem_nx = (rem2 >= 4'd7) ? 3'(rem2 - 4'd7) : rem2[2:0];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (gnt_found) state_nx = SHIFT;
      SHIFT: if (cnt == CW'(1)) state_nx = DONE;
      DONE:  if (Res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      rem    <= '0;
      sreg   <= '0;
      cnt    <= '0;
      res_id <= '0;
      last   <= IDW'(NREQ - 1);
    end else begin
      state <= state_nx;
      if (take) begin
        sreg   <= gnt_data;
        rem    <= '0;
        cnt    <= CW'(WIDTH);
        res_id <= gnt_idx;
        last   <= gnt_idx;
      end else if (state == SHIFT) begin
        rem  <= rem_nx;
        sreg <= sreg << 1;
        cnt  <= cnt - CW'(1);
      end
    end
  end

  assign Res_valid     = (state == DONE);
  assign Res_id        = res_id;
  assign Res_remainder = rem;
  assign Res_divisible = (state == DONE) && (rem == 3'd0);
  assign Busy          = (state != IDLE);

endmodule

// File: tb/tb_divisibility_scheduler.sv
// Directed bench for divisibility_scheduler.
// Hand-computed remainders, grant order and timing.
module tb_divisibility_scheduler;

  logic        Clock;
  logic        Reset;
  logic [3:0]  Req_valid;
  logic [31:0] Req_data;
  logic [3:0]  Req_ready;
  logic        Res_valid;
  logic        Res_ready;
  logic [1:0]  Res_id;
  logic [2:0]  Res_remainder;
  logic        Res_divisible;
  logic        Busy;

  int errs;
  int checks;

  divisibility_scheduler #(
    .NREQ(4), .WIDTH(8), .IDW(2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Req_valid(Req_valid),
    .Req_data(Req_data),
    .Req_ready(Req_ready),
    .Res_valid(Res_valid),
    .Res_ready(Res_ready),
    .Res_id(Res_id),
    .Res_remainder(Res_remainder),
    .Res_divisible(Res_divisible),
    .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_word(input int id,
                         input logic [7:0] d,
                         input logic [2:0] er,
                         input int hold);
    int   n;
    logic ok;
    Req_valid = '0;
    Req_valid[id] = 1'b1;
    Req_data[id*8 +: 8] = d;
    #1;
    chk("grant", 32'(Req_ready), 32'(1 << id));
    @(posedge Clock); #1;
    Req_valid = '0;
    chk("busy", 32'(Busy), 1);
    n = 0;
    while (!Res_valid && n < 20) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("lat", n, 8);
    chk("id", 32'(Res_id), id);
    chk("rem", 32'(Res_remainder), 32'(er));
    chk("div", 32'(Res_divisible), 32'(er == 3'd0));
    if (hold > 0) begin
      ok = 1'b1;
      Req_valid = '1;
      for (int i = 0; i < hold; i++) begin
        @(posedge Clock); #1;
        if (!Res_valid || Res_id != 2'(id) ||
            Res_remainder != er || Req_ready != 4'd0 || !Busy)
          ok = 1'b0;
      end
      chk("hold", 32'(ok), 1);
      Req_valid = '0;
    end
    Res_ready = 1'b1;
    @(posedge Clock); #1;
    Res_ready = 1'b0;
    chk("ack", 32'(Res_valid), 0);
    chk("idle", 32'(Busy), 0);
  endtask

  initial begin
    int   exp_g [5];
    int   exp_r [4];
    int   ng, nr, lastc;
    logic drop;
    errs = 0;
    checks = 0;
    Reset = 1'b0;
    Req_valid = '0;
    Req_data = '0;
    Res_ready = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_ready", 32'(Req_ready), 0);
    chk("rst_valid", 32'(Res_valid), 0);
    chk("rst_rem", 32'(Res_remainder), 0);
    chk("rst_div", 32'(Res_divisible), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_id", 32'(Res_id), 0);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;

    do_word(0, 8'd49, 3'd0, 0);
    do_word(0, 8'd50, 3'd1, 0);
    do_word(0, 8'hFF, 3'd3, 0);
    do_word(0, 8'd0, 3'd0, 0);
    do_word(0, 8'd6, 3'd6, 0);
    do_word(3, 8'd40, 3'd5, 0);
    do_word(2, 8'd100, 3'd2, 0);
    do_word(1, 8'd27, 3'd6, 20);

    Req_valid = 4'b0100;
    Req_data[23:16] = 8'd77;
    #1;
    chk("mid_grant", 32'(Req_ready), 4);
    repeat (4) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    chk("mid_busy", 32'(Busy), 0);
    chk("mid_valid", 32'(Res_valid), 0);
    Req_valid = '0;
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;

    exp_g = '{0, 1, 2, 3, 0};
    exp_r = '{3, 6, 2, 5};
    Req_data = {8'd40, 8'd30, 8'd20, 8'd10};
    Req_valid = 4'b1111;
    Res_ready = 1'b1;
    #1;
    ng = 0;
    nr = 0;
    lastc = 0;
    drop = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (Req_ready != 4'd0 && ng < 5) begin
        chk("rr_order", 32'(Req_ready), 32'(1 << exp_g[ng]));
        if (ng > 0) chk("rr_gap", c - lastc, 10);
        lastc = c;
        ng++;
      end
      if (Res_valid && nr < 5) begin
        chk("rr_id", 32'(Res_id), exp_g[nr]);
        chk("rr_rem", 32'(Res_remainder), exp_r[exp_g[nr]]);
        nr++;
      end
      if (drop) Req_valid = '0;
      if (ng == 5) drop = 1'b1;
      if (ng == 5 && nr == 5) break;
      @(posedge Clock); #1;
    end
    chk("rr_grants", ng, 5);
    chk("rr_results", nr, 5);
    Res_ready = 1'b0;
    Req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
